// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative mul/div unit; ports clk, rst, i_valid/o_ready/i_op/i_arg1/i_arg2 request, i_flush abort, o_valid/i_ready/o_result response
module muldiv_iter #(
  parameter int wd_regs_p = 32,
  parameter int bits_per_cycle_p = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_op,
  input  logic [wd_regs_p-1:0] i_arg1,
  input  logic [wd_regs_p-1:0] i_arg2,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [wd_regs_p-1:0] o_result
);
  localparam int w_l = wd_regs_p;
  localparam int n_l = wd_regs_p / bits_per_cycle_p;
  localparam int cw_l = $clog2(n_l) + 1;
  localparam logic [cw_l-1:0] last_l = cw_l'(n_l - 1);
  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] calc_s = 2'd1;
  localparam logic [1:0] done_s = 2'd2;

  function automatic logic [2*w_l-1:0] f_step(input logic [2*w_l-1:0] p_in, input logic [w_l-1:0] m, input logic dv);
    logic [2*w_l-1:0] p;
    logic [w_l:0] t;
    p = p_in;
    for (int k = 0; k < bits_per_cycle_p; k++) begin
      if (dv) begin
        t = {p[2*w_l-1:w_l], p[w_l-1]};
        p = t >= {1'b0, m} ? {t[w_l-1:0] - m, p[w_l-2:0], 1'b1} : {t[w_l-1:0], p[w_l-2:0], 1'b0};
      end else begin
        t = {1'b0, p[2*w_l-1:w_l]} + (p[0] ? {1'b0, m} : '0);
        p = {t, p[w_l-1:1]};
      end
    end
    return p;
  endfunction

  logic [1:0] r_state, w_next;
  logic [2:0] r_op;
  logic [w_l-1:0] r_a, r_b, r_result;
  logic [2*w_l-1:0] r_prod, w_prod_nxt, w_mul;
  logic [cw_l-1:0] r_cnt;
  logic r_neg;
  logic w_accept, w_s1, w_s2, w_an, w_bn, w_dz, w_ovf, w_spec, w_last;
  logic [w_l-1:0] w_amag, w_bmag, w_dv, w_res, w_spec_res;

  assign w_accept = r_state == idle_s && i_valid && !i_flush;
  assign w_s1 = i_op == 3'd1 || i_op == 3'd2 || i_op == 3'd4 || i_op == 3'd6;
  assign w_s2 = i_op == 3'd1 || i_op == 3'd4 || i_op == 3'd6;
  assign w_an = w_s1 && i_arg1[w_l-1];
  assign w_bn = w_s2 && i_arg2[w_l-1];
  assign w_amag = w_an ? -i_arg1 : i_arg1;
  assign w_bmag = w_bn ? -i_arg2 : i_arg2;
  assign w_dz = i_op[2] && i_arg2 == '0;
  assign w_ovf = (i_op == 3'd4 || i_op == 3'd6) && i_arg1 == {1'b1, {(w_l-1){1'b0}}} && i_arg2 == '1;
  assign w_spec = w_dz || w_ovf;
  assign w_spec_res = w_dz ? (i_op[1] ? i_arg1 : '1) : (i_op[1] ? '0 : i_arg1);
  assign w_last = r_cnt == last_l;
  assign w_prod_nxt = f_step(r_prod, r_op[2] ? r_b : r_a, r_op[2]);
  assign w_mul = r_neg ? -w_prod_nxt : w_prod_nxt;
  assign w_dv = r_op[1] ? w_prod_nxt[2*w_l-1:w_l] : w_prod_nxt[w_l-1:0];
  assign w_res = r_op[2] ? (r_neg ? -w_dv : w_dv) : r_op == 3'd0 ? w_mul[w_l-1:0] : w_mul[2*w_l-1:w_l];
  assign o_result = r_result;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= idle_s;
    else r_state <= w_next;

  always_comb
    w_next = i_flush ? idle_s
      : r_state == idle_s ? (i_valid ? (w_spec ? done_s : calc_s) : idle_s)
      : r_state == calc_s ? (w_last ? done_s : calc_s)
      : r_state == done_s ? (i_ready ? idle_s : done_s)
      : idle_s;

  always_comb begin
    o_ready = r_state == idle_s;
    o_valid = r_state == done_s;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
      r_prod <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op <= i_op;
      r_a <= w_amag;
      r_b <= w_bmag;
      r_neg <= i_op[2] && i_op[1] ? w_an : w_an ^ w_bn;
      r_cnt <= '0;
      r_prod <= {{w_l{1'b0}}, i_op[2] ? w_amag : w_bmag};
      if (w_spec) r_result <= w_spec_res;
    end else if (r_state == calc_s) begin
      r_prod <= w_prod_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_res;
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed self-checking bench for muldiv_iter (32-bit radix-2 and radix-16 instances)
module tb_muldiv_iter;
  logic clk = 1'b0, rst = 1'b1;
  logic i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [2:0] i_op = '0;
  logic [31:0] i_arg1 = '0, i_arg2 = '0;
  logic o_ready, o_valid;
  logic [31:0] o_result;
  logic v2 = 1'b0;
  logic [2:0] op2 = '0;
  logic [31:0] a2 = '0, b2 = '0;
  logic rdy2, val2;
  logic [31:0] res2;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.wd_regs_p(32), .bits_per_cycle_p(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_arg1(i_arg1), .i_arg2(i_arg2), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result)
  );

  muldiv_iter #(.wd_regs_p(32), .bits_per_cycle_p(4)) dut4 (
    .clk(clk), .rst(rst), .i_valid(v2), .o_ready(rdy2), .i_op(op2),
    .i_arg1(a2), .i_arg2(b2), .i_flush(1'b0), .o_valid(val2),
    .i_ready(1'b1), .o_result(res2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1'b1;
    i_op = op;
    i_arg1 = a;
    i_arg2 = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_op = 3'($urandom);
    i_arg1 = $urandom;
    i_arg2 = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!o_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic watch(input int cycles, output logic seen);
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      seen |= o_valid;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input int lat);
    int n;
    issue(op, a, b);
    wait_done(n);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk(tag, o_result, exp_r);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk({tag, "_idle"}, 32'({o_ready, o_valid}), 32'd2);
  endtask

  initial begin
    int n;
    logic seen;
    #12;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_result", o_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    run("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("remu_z", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    chk("stall_lat", 32'(n), 32'd33);
    i_valid = 1'b1;
    i_op = 3'd0;
    i_arg1 = 32'd5;
    i_arg2 = 32'd6;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'({o_valid, o_ready}), 32'd2);
      chk("stall_result", o_result, 32'hFFFFFFFE);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk("stall_idle", 32'({o_ready, o_valid}), 32'd2);
    watch(40, seen);
    chk("stall_no_accept", 32'(seen), 32'd0);
    issue(3'd0, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    chk("flush_idle", 32'({o_ready, o_valid}), 32'd2);
    watch(40, seen);
    chk("flush_no_valid", 32'(seen), 32'd0);
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_op = 3'd0;
    i_arg1 = 32'd3;
    i_arg2 = 32'd3;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("flush_accept_ready", 32'(o_ready), 32'd1);
    watch(40, seen);
    chk("flush_accept_no_valid", 32'(seen), 32'd0);
    issue(3'd0, 32'd11, 32'd13);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_result", o_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch(40, seen);
    chk("arst_no_valid", 32'(seen), 32'd0);
    run("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    v2 = 1'b1;
    op2 = 3'd5;
    a2 = 32'd100;
    b2 = 32'd7;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    a2 = 32'd1;
    b2 = 32'd1;
    n = 1;
    while (!val2 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("divu4_lat", 32'(n), 32'd9);
    chk("divu4", res2, 32'd14);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter: wd_regs_p, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter: bits_per_cycle_p, default 1, iteration radix in bits. Legal values are 1, 2 and 4, and it SHALL divide wd_regs_p.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: i_valid  in  1  request valid.
REQ-006 SHALL have port: o_ready  out  1  unit can accept a request.
REQ-007 SHALL have port: i_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have port: i_arg1  in  wd_regs_p  rs1 operand (multiplicand/dividend).
REQ-009 SHALL have port: i_arg2  in  wd_regs_p  rs2 operand (multiplier/divisor).
REQ-010 SHALL have port: i_flush  in  1  abort any in-flight operation.
REQ-011 SHALL have port: o_valid  out  1  result valid.
REQ-012 SHALL have port: i_ready  in  1  consumer accepts result.
REQ-013 SHALL have port: o_result  out  wd_regs_p  result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE; o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-015 SHALL accept a request on a rising edge with i_valid=1, o_ready=1 and i_flush=0. On acceptance it SHALL register i_op, i_arg1 and i_arg2; later input changes SHALL NOT affect the result.
REQ-016 On accept of a normal operation, the unit SHALL go IDLE->CALC and stay in CALC for exactly N=wd_regs_p/bits_per_cycle_p edges, then enter DONE; o_valid SHALL rise N+1 edges after the accepting edge.
REQ-017 Multiply SHALL form the full 2*wd_regs_p product, shift-add, bits_per_cycle_p multiplier bits per cycle. MUL SHALL return the low half. MULH (signed x signed), MULHSU (signed x unsigned) and MULHU (unsigned x unsigned) SHALL return the high half.
REQ-018 Divide SHALL be restoring/non-restoring, bits_per_cycle_p quotient bits per cycle, on magnitudes. For signed ops, the quotient SHALL be negated if operand signs differ, the remainder SHALL take the dividend's sign, and division SHALL truncate toward zero.
REQ-019 Divide-by-zero (i_arg2=0, ops 4-7) SHALL skip CALC (IDLE->DONE, o_valid one edge after accept). DIV/DIVU SHALL return all-ones; REM/REMU SHALL return i_arg1.
REQ-020 Signed overflow (DIV/REM, i_arg1=most-negative, i_arg2=all-ones) SHALL skip CALC as in REQ-019. DIV SHALL return i_arg1; REM SHALL return 0.
REQ-021 In DONE, o_result and o_valid SHALL hold stable until an edge with i_ready=1. That edge SHALL move the unit to IDLE; there is no same-cycle re-accept, so the minimum issue interval is N+2 edges (2 for special cases).
REQ-022 i_flush=1 SHALL move the unit to IDLE on the next edge from any state, dropping the operation; o_valid SHALL be 0 from that edge. Flush SHALL take priority over accept and over the result handshake.
REQ-023 o_result SHALL retain its last value outside DONE; its value outside DONE has no meaning.
REQ-024 The unit SHALL have no combinational path from i_valid, i_ready or i_flush to any output.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, o_valid=0, o_ready=1, o_result=0 and clear all iteration registers, without waiting for a clock edge.
REQ-026 Reset asserted in CALC or DONE SHALL discard the operation; no o_valid SHALL follow the release of reset.
REQ-027 The first accept after reset SHALL be possible on the first rising edge with rst=0.

Verification (wd_regs_p=32, bits_per_cycle_p=1 unless noted)
REQ-028 The bench SHALL cover: MUL 7 x 0xFFFFFFFD -> o_result 0xFFFFFFEB, o_valid exactly 33 edges after accept; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-029 The bench SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM of the same operands -> 0xFFFFFFFF. With bits_per_cycle_p=4, DIVU 100 / 7 -> 14 with o_valid 9 edges after accept.
REQ-030 The bench SHALL cover: DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same -> 0. Each SHALL have o_valid one edge after accept.
REQ-031 The bench SHALL cover: result with i_ready held 0 for 5 cycles -> o_valid and o_result stable throughout, then IDLE one edge after i_ready=1. A new i_valid during DONE SHALL NOT be accepted.
REQ-032 The bench SHALL cover: i_flush pulsed at CALC cycle 10 -> IDLE next edge, with no o_valid; i_flush with i_valid in IDLE -> no accept.
REQ-033 The bench SHALL cover: rst asserted asynchronously mid-CALC, between clock edges -> o_valid=0 and o_ready=1 before the next edge. After release, MUL 3 x 4 -> 12 with normal latency.
